// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the fetch (imem) and
// data (dmem) requesters. Each side has a one-entry pending buffer, one
// transaction is in flight downstream at a time, dmem has priority, and a
// starvation counter makes sure fetch still makes progress.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        proto_err
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        i_pend_q, i_pend_d;
  logic [31:0] i_addr_q, i_addr_d;
  logic [3:0]  i_rmask_q, i_rmask_d;
  logic        d_pend_q, d_pend_d;
  logic [31:0] d_addr_q, d_addr_d;
  logic [3:0]  d_rmask_q, d_rmask_d;
  logic [3:0]  d_wmask_q, d_wmask_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic        proto_err_q, proto_err_d;

  logic        i_req, d_req, d_both;
  logic        i_busy, d_busy, i_take, d_take, i_cand, d_cand;
  logic        arb_en, grant_i, grant_d;
  logic [31:0] i_sel_addr, d_sel_addr, d_sel_wdata;
  logic [3:0]  i_sel_rmask, d_sel_rmask, d_sel_wmask, d_in_rmask;

  // Candidate selection and arbitration; a requester whose transaction gets
  // its response this cycle may already issue its next request.
  always_comb begin
    i_req  = |imem_rmask;
    d_req  = (|dmem_rmask) || (|dmem_wmask);
    d_both = (|dmem_rmask) && (|dmem_wmask);
    // A read+write pulse is treated as a write.
    d_in_rmask = (|dmem_wmask) ? 4'h0 : dmem_rmask;

    i_busy = i_pend_q || (state_q == BUSY_I && !mem_resp);
    d_busy = d_pend_q || (state_q == BUSY_D && !mem_resp);
    i_take = i_req && !i_busy;
    d_take = d_req && !d_busy;
    i_cand = i_pend_q || i_take;
    d_cand = d_pend_q || d_take;

    i_sel_addr  = i_pend_q ? i_addr_q  : imem_addr;
    i_sel_rmask = i_pend_q ? i_rmask_q : imem_rmask;
    d_sel_addr  = d_pend_q ? d_addr_q  : dmem_addr;
    d_sel_rmask = d_pend_q ? d_rmask_q : d_in_rmask;
    d_sel_wmask = d_pend_q ? d_wmask_q : dmem_wmask;
    d_sel_wdata = d_pend_q ? d_wdata_q : dmem_wdata;

    arb_en  = rst && (state_q == IDLE || mem_resp);
    grant_d = arb_en && d_cand && ((starve_cnt_q < LIMIT) || !i_cand);
    grant_i = arb_en && i_cand && !grant_d;
  end

  // Next-state: FSM, pending buffers, starvation counter, sticky error.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    i_pend_d     = i_pend_q;
    i_addr_d     = i_addr_q;
    i_rmask_d    = i_rmask_q;
    d_pend_d     = d_pend_q;
    d_addr_d     = d_addr_q;
    d_rmask_d    = d_rmask_q;
    d_wmask_d    = d_wmask_q;
    d_wdata_d    = d_wdata_q;

    if (arb_en) begin
      if (grant_d)      state_d = BUSY_D;
      else if (grant_i) state_d = BUSY_I;
      else              state_d = IDLE;
    end

    if (grant_i) begin
      i_pend_d = 1'b0;
    end else if (i_take) begin
      i_pend_d  = 1'b1;
      i_addr_d  = imem_addr;
      i_rmask_d = imem_rmask;
    end

    if (grant_d) begin
      d_pend_d = 1'b0;
    end else if (d_take) begin
      d_pend_d  = 1'b1;
      d_addr_d  = dmem_addr;
      d_rmask_d = d_in_rmask;
      d_wmask_d = dmem_wmask;
      d_wdata_d = dmem_wdata;
    end

    if (!i_cand || grant_i)
      starve_cnt_d = 4'h0;
    else if (grant_d && starve_cnt_q < LIMIT)
      starve_cnt_d = starve_cnt_q + 4'h1;

    proto_err_d = proto_err_q
                | (i_req && i_busy)
                | (d_req && d_busy)
                | (state_q == IDLE && mem_resp)
                | d_both;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= 4'h0;
      i_pend_q     <= 1'b0;
      i_addr_q     <= 32'h0;
      i_rmask_q    <= 4'h0;
      d_pend_q     <= 1'b0;
      d_addr_q     <= 32'h0;
      d_rmask_q    <= 4'h0;
      d_wmask_q    <= 4'h0;
      d_wdata_q    <= 32'h0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      i_pend_q     <= i_pend_d;
      i_addr_q     <= i_addr_d;
      i_rmask_q    <= i_rmask_d;
      d_pend_q     <= d_pend_d;
      d_addr_q     <= d_addr_d;
      d_rmask_q    <= d_rmask_d;
      d_wmask_q    <= d_wmask_d;
      d_wdata_q    <= d_wdata_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Downstream issue is a same-cycle pass-through of the granted request.
  assign mem_rmask = grant_d ? d_sel_rmask : (grant_i ? i_sel_rmask : 4'h0);
  assign mem_wmask = grant_d ? d_sel_wmask : 4'h0;
  assign mem_addr  = grant_d ? d_sel_addr  : (grant_i ? i_sel_addr : 32'h0);
  assign mem_wdata = grant_d ? d_sel_wdata : 32'h0;

  // Responses go only to the owner of the in-flight transaction.
  assign imem_resp  = rst && state_q == BUSY_I && mem_resp;
  assign dmem_resp  = rst && state_q == BUSY_D && mem_resp;
  assign imem_rdata = imem_resp ? mem_rdata : 32'h0;
  assign dmem_rdata = dmem_resp ? mem_rdata : 32'h0;
  assign proto_err  = proto_err_q;

endmodule
